// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter that shares one UART transmitter between NREQ byte requesters, with a per-frame watchdog.
// Latency: a byte accepted in cycle N is launched (uart_start) in N+1; the next grant can come in the cycle after uart_tx_done.
// Backpressure: grants only while idle and the transmitter is not busy; req_ready is a one-cycle one-hot accept pulse.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 200000,
    localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW         = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_start,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    input  logic              uart_tx_done,
    output logic [IW-1:0]     grant_id,
    output logic              arb_busy,
    output logic              timeout_err,
    output logic [IW-1:0]     err_id
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            win_vld;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            grant_go;
    logic            term;

    // Round-robin pick: first valid requester after the last winner, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!win_vld && req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign grant_go = (state_q == S_IDLE) && win_vld && !uart_tx_busy;
    // Watchdog terminal count; a done in the same cycle takes precedence.
    assign term     = (cnt_q == CW'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; done outside WAIT is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_go) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (uart_tx_done || term) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready is combinational in the grant cycle only.
    always_comb begin
        req_ready   = '0;
        uart_start  = 1'b0;
        timeout_err = 1'b0;
        arb_busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                for (int i = 0; i < NREQ; i++)
                    req_ready[i] = grant_go && (win_idx == IW'(i));
            end
            S_LAUNCH: begin
                uart_start = 1'b1;
                arb_busy   = 1'b1;
            end
            S_WAIT: begin
                arb_busy    = 1'b1;
                timeout_err = term && !uart_tx_done;
            end
            default: ;
        endcase
    end

    // Datapath next-state: byte/grant capture, watchdog counter, error index.
    always_comb begin
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_go) begin
                    for (int i = 0; i < NREQ; i++)
                        if (win_idx == IW'(i)) data_d = req_data[i*8 +: 8];
                    grant_d = win_idx;
                    last_d  = win_idx;
                end
            end
            S_LAUNCH: cnt_d = '0;
            S_WAIT: begin
                if (!term) cnt_d = cnt_q + CW'(1);
                if (term && !uart_tx_done) err_d = grant_q;
            end
            default: ;
        endcase
    end

    // Datapath registers; last winner resets to NREQ-1 so requester 0 goes first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= 8'h00;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign uart_tx_data = data_q;
    assign grant_id     = grant_q;
    assign err_id       = err_q;

endmodule
